// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared types and constants for the common data bus (CDB) arbiter.
//   CDB_N_REQ        : number of writeback requesters sharing the CDB
//   cdb_src_e        : requester index; lower index = higher fixed priority
//   CDB_STARVE_LIMIT : wait cycles before a buffered entry gets override
//   cdb_entry_t      : packed CDB payload; the arbiter treats it as opaque
// ---------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int CDB_N_REQ        = 4;
  localparam int CDB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    CDB_SRC_BR  = 2'd0,
    CDB_SRC_LSQ = 2'd1,
    CDB_SRC_MUL = 2'd2,
    CDB_SRC_ALU = 2'd3
  } cdb_src_e;

  // One broadcast result. Total width is 96 bits.
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] target;
    logic [5:0]  rob_idx;
    logic [4:0]  rd;
    logic [4:0]  exc_cause;
    logic        br_taken;
    logic        br_mispredict;
    logic        is_store;
    logic [12:0] rsvd;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the requester handshakes and the registered CDB broadcast.
//   flush        : pipeline flush, blocks accept/grant for the cycle
//   req_valid    : per-requester result valid
//   req_ready    : per-requester holding buffer can accept
//   req_payload  : packed payloads, slice i = [i*PAYLOAD_W +: PAYLOAD_W]
//   cdb_valid    : registered broadcast valid
//   cdb_payload  : registered broadcast payload
//   cdb_src      : registered one-hot source of the broadcast
//   buf_occupied : per-requester holding buffer full
//
// Handshake: a transfer on requester i happens on a rising clk edge where
// req_valid[i] and req_ready[i] are both high. req_ready never depends on
// req_valid; a requester may hold req_valid high with a stable payload
// until it sees ready, and the arbiter may raise or drop ready at any cycle.
// The CDB side has no backpressure: cdb_valid is a one-cycle broadcast.
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int PAYLOAD_W = 96
);

  logic                       flush;
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ*PAYLOAD_W-1:0] req_payload;
  logic                       cdb_valid;
  logic [PAYLOAD_W-1:0]       cdb_payload;
  logic [N_REQ-1:0]           cdb_src;
  logic [N_REQ-1:0]           buf_occupied;

  // Producer side (writeback stages / flush source)
  modport master (
    output flush, req_valid, req_payload,
    input  req_ready, cdb_valid, cdb_payload, cdb_src, buf_occupied
  );

  // Arbiter side
  modport slave (
    input  flush, req_valid, req_payload,
    output req_ready, cdb_valid, cdb_payload, cdb_src, buf_occupied
  );

endinterface

// File: rtl/cdb_prio_pick.sv
// ---------------------------------------------------------------------------
// cdb_prio_pick
// One-hot picker: keeps only the lowest-index set bit of req.
//   req : request vector
//   gnt : one-hot of lowest set bit of req, or zero when req is zero
// ---------------------------------------------------------------------------
module cdb_prio_pick #(
  parameter int W = 4
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Shares the single CDB between writeback requesters. Each requester has a
// one-entry holding buffer; every cycle at most one buffered entry is
// granted (fixed priority, index 0 highest, with an anti-starvation
// override) and broadcast through a registered CDB output.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : cdb_arbiter_if.slave (handshakes, flush, CDB broadcast)
// Latency: accept at edge T -> granted in cycle T+1 -> on cdb_* after T+2.
// ---------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ        = CDB_N_REQ,
  parameter int PAYLOAD_W    = $bits(cdb_entry_t),
  parameter int STARVE_LIMIT = CDB_STARVE_LIMIT
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [N_REQ-1:0]                buf_valid;
  logic [N_REQ-1:0][PAYLOAD_W-1:0] buf_data;
  logic [N_REQ-1:0][CW-1:0]        wait_cnt;

  logic [N_REQ-1:0]     starve;
  logic [N_REQ-1:0]     pick_starve;
  logic [N_REQ-1:0]     pick_buf;
  logic [N_REQ-1:0]     grant;
  logic [N_REQ-1:0]     ready;
  logic [N_REQ-1:0]     accept;
  logic [PAYLOAD_W-1:0] grant_data;

  logic                 cdb_valid_q;
  logic [N_REQ-1:0]     cdb_src_q;
  logic [PAYLOAD_W-1:0] cdb_payload_q;

  // Entries that have waited the full limit jump ahead of fixed priority.
  always_comb begin
    starve = '0;
    for (int i = 0; i < N_REQ; i++) begin
      starve[i] = buf_valid[i] && (wait_cnt[i] == LIMIT);
    end
  end

  cdb_prio_pick #(.W(N_REQ)) u_pick_starve (
    .req (starve),
    .gnt (pick_starve)
  );

  cdb_prio_pick #(.W(N_REQ)) u_pick_buf (
    .req (buf_valid),
    .gnt (pick_buf)
  );

  // Grant uses registered state only, so req_valid never reaches req_ready.
  assign grant  = bus.flush ? '0 : ((|starve) ? pick_starve : pick_buf);
  // A granted buffer drains this edge, so it can take a new entry at once.
  assign ready  = ~{N_REQ{bus.flush}} & (~buf_valid | grant);
  assign accept = bus.req_valid & ready;

  // grant is one-hot or zero, so an AND-OR mux is sufficient.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_data = grant_data | buf_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= '0;
      buf_data  <= '0;
      wait_cnt  <= '0;
    end else if (bus.flush) begin
      buf_valid <= '0;
      wait_cnt  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          // Also covers grant+accept on the same source: reload in place.
          buf_valid[i] <= 1'b1;
          buf_data[i]  <= bus.req_payload[i*PAYLOAD_W +: PAYLOAD_W];
          wait_cnt[i]  <= '0;
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
          wait_cnt[i]  <= '0;
        end else if (buf_valid[i] && (wait_cnt[i] != LIMIT)) begin
          wait_cnt[i]  <= wait_cnt[i] + CW'(1);
        end
      end
    end
  end

  // During flush grant is zero, so this register clears on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q   <= 1'b0;
      cdb_src_q     <= '0;
      cdb_payload_q <= '0;
    end else begin
      cdb_valid_q   <= |grant;
      cdb_src_q     <= grant;
      cdb_payload_q <= grant_data;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.buf_occupied = buf_valid;
  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_src      = cdb_src_q;
  assign bus.cdb_payload  = cdb_payload_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed table of per-cycle vectors for cdb_arbiter (single source,
// contention, starvation, back-to-back, flush) followed by a hand-written
// asynchronous reset sequence. Each table row gives the inputs for one
// cycle and the outputs expected in that same cycle.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int PW = 96;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(NR), .PAYLOAD_W(PW)) bus ();

  cdb_arbiter #(.N_REQ(NR), .PAYLOAD_W(PW), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       flush;
    logic [3:0] valid;
    logic [3:0] ready;
    logic       cv;
    logic [3:0] src;
    int         prow;   // table row in which the broadcast entry was accepted
    logic [3:0] occ;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_payload(input int row, input int src);
    return {64'h0, row[15:0], src[7:0], 8'hC5};
  endfunction

  function automatic int oh_idx(input logic [3:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) idx = i;
    return idx;
  endfunction

  task automatic add_v(input logic fl, input logic [3:0] v, input logic [3:0] rdy,
                       input logic cv, input logic [3:0] src, input int prow,
                       input logic [3:0] occ);
    vec_t e;
    e.flush = fl; e.valid = v; e.ready = rdy; e.cv = cv;
    e.src = src; e.prow = prow; e.occ = occ;
    vq.push_back(e);
  endtask

  task automatic build_table();
    //     flush valid    ready    cv   src      prow occ
    // single source on ALU
    add_v(0, 4'b1000, 4'b1111, 0, 4'b0000, 0,  4'b0000); // 0
    add_v(0, 4'b0000, 4'b1111, 0, 4'b0000, 0,  4'b1000); // 1
    add_v(0, 4'b0000, 4'b1111, 1, 4'b1000, 0,  4'b0000); // 2
    add_v(0, 4'b0000, 4'b1111, 0, 4'b0000, 0,  4'b0000); // 3
    // all four at once: drained 0,1,2,3 with no gap
    add_v(0, 4'b1111, 4'b1111, 0, 4'b0000, 0,  4'b0000); // 4
    add_v(0, 4'b0000, 4'b0001, 0, 4'b0000, 0,  4'b1111); // 5
    add_v(0, 4'b0000, 4'b0011, 1, 4'b0001, 4,  4'b1110); // 6
    add_v(0, 4'b0000, 4'b0111, 1, 4'b0010, 4,  4'b1100); // 7
    add_v(0, 4'b0000, 4'b1111, 1, 4'b0100, 4,  4'b1000); // 8
    add_v(0, 4'b0000, 4'b1111, 1, 4'b1000, 4,  4'b0000); // 9
    add_v(0, 4'b0000, 4'b1111, 0, 4'b0000, 0,  4'b0000); // 10
    // starvation: src0 keeps winning until src1/src3 hit the limit
    add_v(0, 4'b1011, 4'b1111, 0, 4'b0000, 0,  4'b0000); // 11
    add_v(0, 4'b0011, 4'b0101, 0, 4'b0000, 0,  4'b1011); // 12
    add_v(0, 4'b0011, 4'b0101, 1, 4'b0001, 11, 4'b1011); // 13
    add_v(0, 4'b0011, 4'b0101, 1, 4'b0001, 12, 4'b1011); // 14
    add_v(0, 4'b0011, 4'b0101, 1, 4'b0001, 13, 4'b1011); // 15
    add_v(0, 4'b0011, 4'b0110, 1, 4'b0001, 14, 4'b1011); // 16 src1 starved
    add_v(0, 4'b0011, 4'b1100, 1, 4'b0010, 11, 4'b1011); // 17 src3 starved
    add_v(0, 4'b0000, 4'b1101, 1, 4'b1000, 11, 4'b0011); // 18
    add_v(0, 4'b0000, 4'b1111, 1, 4'b0001, 15, 4'b0010); // 19
    add_v(0, 4'b0000, 4'b1111, 1, 4'b0010, 16, 4'b0000); // 20
    add_v(0, 4'b0000, 4'b1111, 0, 4'b0000, 0,  4'b0000); // 21
    // back-to-back on mult/div
    add_v(0, 4'b0100, 4'b1111, 0, 4'b0000, 0,  4'b0000); // 22
    add_v(0, 4'b0100, 4'b1111, 0, 4'b0000, 0,  4'b0100); // 23
    add_v(0, 4'b0100, 4'b1111, 1, 4'b0100, 22, 4'b0100); // 24
    add_v(0, 4'b0000, 4'b1111, 1, 4'b0100, 23, 4'b0100); // 25
    add_v(0, 4'b0000, 4'b1111, 1, 4'b0100, 24, 4'b0000); // 26
    add_v(0, 4'b0000, 4'b1111, 0, 4'b0000, 0,  4'b0000); // 27
    // flush with 3 buffers full, ALU request in the flush cycle is dropped
    add_v(0, 4'b0111, 4'b1111, 0, 4'b0000, 0,  4'b0000); // 28
    add_v(1, 4'b1000, 4'b0000, 0, 4'b0000, 0,  4'b0111); // 29
    add_v(0, 4'b0000, 4'b1111, 0, 4'b0000, 0,  4'b0000); // 30
    // flush while a broadcast is on the CDB: it stays visible that cycle
    add_v(0, 4'b0011, 4'b1111, 0, 4'b0000, 0,  4'b0000); // 31
    add_v(0, 4'b0000, 4'b1101, 0, 4'b0000, 0,  4'b0011); // 32
    add_v(1, 4'b0000, 4'b0000, 1, 4'b0001, 31, 4'b0010); // 33
    add_v(0, 4'b0000, 4'b1111, 0, 4'b0000, 0,  4'b0000); // 34
  endtask

  initial begin
    logic [PW-1:0] exp_pl;
    bus.flush       = 1'b0;
    bus.req_valid   = '0;
    bus.req_payload = '0;
    build_table();

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset cdb_valid",    PW'(bus.cdb_valid),    '0);
    check("reset cdb_src",      PW'(bus.cdb_src),      '0);
    check("reset cdb_payload",  bus.cdb_payload,       '0);
    check("reset buf_occupied", PW'(bus.buf_occupied), '0);
    check("reset req_ready",    PW'(bus.req_ready),    PW'(4'b1111));
    check("reset wait_cnt",     PW'(dut.wait_cnt),     '0);

    // table-driven cycles
    for (int r = 0; r < vq.size(); r++) begin
      @(posedge clk);
      #1;
      bus.flush     = vq[r].flush;
      bus.req_valid = vq[r].valid;
      for (int i = 0; i < NR; i++) bus.req_payload[i*PW +: PW] = mk_payload(r, i);
      #1;
      exp_pl = vq[r].cv ? mk_payload(vq[r].prow, oh_idx(vq[r].src)) : '0;
      check($sformatf("row%0d req_ready", r),    PW'(bus.req_ready),    PW'(vq[r].ready));
      check($sformatf("row%0d cdb_valid", r),    PW'(bus.cdb_valid),    PW'(vq[r].cv));
      check($sformatf("row%0d cdb_src", r),      PW'(bus.cdb_src),      PW'(vq[r].src));
      check($sformatf("row%0d cdb_payload", r),  bus.cdb_payload,       exp_pl);
      check($sformatf("row%0d buf_occupied", r), PW'(bus.buf_occupied), PW'(vq[r].occ));
      if (r == 18) check("row18 wait_cnt3", PW'(dut.wait_cnt[3]), '0);
    end
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.req_valid = '0;

    // asynchronous reset in the middle of a burst
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) bus.req_payload[i*PW +: PW] = mk_payload(100, i);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(posedge clk);
    #1;
    check("burst cdb_valid", PW'(bus.cdb_valid), PW'(1'b1));
    check("burst cdb_src",   PW'(bus.cdb_src),   PW'(4'b0001));
    #2 rst = 1'b1;
    #1;
    check("async rst cdb_valid",    PW'(bus.cdb_valid),    '0);
    check("async rst cdb_src",      PW'(bus.cdb_src),      '0);
    check("async rst buf_occupied", PW'(bus.buf_occupied), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("post rst req_ready", PW'(bus.req_ready), PW'(4'b1111));
    bus.req_valid = 4'b1000;
    bus.req_payload = '0;
    bus.req_payload[3*PW +: PW] = PW'(8'hAB);
    @(posedge clk);
    #1 bus.req_valid = '0;
    #1;
    check("post rst edge1 cdb_valid", PW'(bus.cdb_valid),    '0);
    check("post rst edge1 occupied",  PW'(bus.buf_occupied), PW'(4'b1000));
    check("post rst edge1 ready3",    PW'(bus.req_ready[3]), PW'(1'b1));
    @(posedge clk);
    #1;
    check("post rst edge2 cdb_valid",   PW'(bus.cdb_valid),    PW'(1'b1));
    check("post rst edge2 cdb_src",     PW'(bus.cdb_src),      PW'(4'b1000));
    check("post rst edge2 cdb_payload", bus.cdb_payload,       PW'(8'hAB));
    check("post rst edge2 occupied",    PW'(bus.buf_occupied), '0);
    check("post rst edge2 wait_cnt3",   PW'(dut.wait_cnt[3]),  '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
